la_clkmux4_ctrl: RTL and testbench

Select controller that drives the sel0..sel3 inputs of the 4-input glitch-free clock mux from a request handshake. It runs on an always-on reference clock and sequences every clock switch break-before-make:
- drop the current select;
- wait a drain interval so the mux's synchronizers and clock gates can close;
- assert the new one-hot select;
- wait a settle interval, then report completion.

Sits between the clock/power management CSR logic (upstream) and la_clkmux4 (downstream).

---
 rtl/la_clkctrl_pkg.sv | 18 +
 rtl/la_clkmux4_ctrl.sv | 132 +++++++++++++
 tb/tb_la_clkmux4_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/la_clkctrl_pkg.sv
// Shared definitions for the la_clkmux4 select controller: state encoding,
// counter width and one-hot select helper.
package la_clkctrl_pkg;

  localparam int unsigned CNTW = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrain  = 2'd1,
    StSettle = 2'd2,
    StFin    = 2'd3
  } state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/la_clkmux4_ctrl.sv
// Break-before-make select sequencer for la_clkmux4: drops the current select,
// drains, raises the new one-hot select, settles, then pulses done.
module la_clkmux4_ctrl
  import la_clkctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES  = 8,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned RESET_SEL     = 0,
  parameter bit          RESET_ON      = 1'b1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_off,
  output logic [3:0] sel,
  output logic [1:0] cur_sel,
  output logic       cur_on,
  output logic       busy,
  output logic       done
);

  if (DRAIN_CYCLES == 0 || DRAIN_CYCLES > 255) begin : g_bad_drain
    $error("DRAIN_CYCLES must be in 1..255");
  end
  if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end
  if (RESET_SEL > 3) begin : g_bad_rst_sel
    $error("RESET_SEL must be in 0..3");
  end

  localparam logic [1:0]      RstSel    = 2'(RESET_SEL);
  localparam logic [3:0]      RstOneHot = RESET_ON ? onehot4(RstSel) : 4'b0000;
  localparam logic [CNTW-1:0] DrainLd   = CNTW'(DRAIN_CYCLES - 1);
  localparam logic [CNTW-1:0] SettleLd  = CNTW'(SETTLE_CYCLES - 1);

  state_e            r_state,   w_state_d;
  logic [CNTW-1:0]   r_cnt,     w_cnt_d;
  logic [3:0]        r_sel,     w_sel_d;
  logic [1:0]        r_cur_sel, w_cur_sel_d;
  logic              r_cur_on,  w_cur_on_d;
  logic [1:0]        r_tgt_sel, w_tgt_sel_d;
  logic              r_tgt_off, w_tgt_off_d;
  logic              w_noop;

  // Request already matches what is committed: nothing to switch.
  assign w_noop = req_off ? !r_cur_on : (r_cur_on && (req_sel == r_cur_sel));

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_sel_d     = r_sel;
    w_cur_sel_d = r_cur_sel;
    w_cur_on_d  = r_cur_on;
    w_tgt_sel_d = r_tgt_sel;
    w_tgt_off_d = r_tgt_off;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          if (w_noop) begin
            w_state_d = StFin;
          end else begin
            w_tgt_sel_d = req_sel;
            w_tgt_off_d = req_off;
            w_sel_d     = 4'b0000;
            w_cur_on_d  = 1'b0;
            w_cnt_d     = DrainLd;
            w_state_d   = StDrain;
          end
        end
      end
      StDrain: begin
        if (r_cnt == '0) begin
          if (r_tgt_off) begin
            w_state_d = StFin;
          end else begin
            w_sel_d   = onehot4(r_tgt_sel);
            w_cnt_d   = SettleLd;
            w_state_d = StSettle;
          end
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StSettle: begin
        if (r_cnt == '0) begin
          w_cur_sel_d = r_tgt_sel;
          w_cur_on_d  = 1'b1;
          w_state_d   = StFin;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StFin: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_sel     <= RstOneHot;
      r_cur_sel <= RstSel;
      r_cur_on  <= RESET_ON;
      r_tgt_sel <= RstSel;
      r_tgt_off <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_sel     <= w_sel_d;
      r_cur_sel <= w_cur_sel_d;
      r_cur_on  <= w_cur_on_d;
      r_tgt_sel <= w_tgt_sel_d;
      r_tgt_off <= w_tgt_off_d;
    end
  end

  assign req_ready = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign done      = (r_state == StFin);
  assign sel       = r_sel;
  assign cur_sel   = r_cur_sel;
  assign cur_on    = r_cur_on;

endmodule

// File: tb/tb_la_clkmux4_ctrl.sv
// Directed bench for la_clkmux4_ctrl using three instances with different
// parameter sets; expected values are hand-derived cycle counts.
module tb_la_clkmux4_ctrl;

  logic clk;
  int   n_cmp;
  int   n_err;

  // Instance A: defaults (drain 8, settle 8, reset on clock 0).
  logic       a_nreset, a_req_valid, a_req_ready, a_req_off, a_cur_on, a_busy, a_done;
  logic [1:0] a_req_sel, a_cur_sel;
  logic [3:0] a_sel;
  // Instance B: reset on clock 2.
  logic       b_nreset, b_req_valid, b_req_ready, b_req_off, b_cur_on, b_busy, b_done;
  logic [1:0] b_req_sel, b_cur_sel;
  logic [3:0] b_sel;
  // Instance C: drain 3, settle 5, reset on clock 0.
  logic       c_nreset, c_req_valid, c_req_ready, c_req_off, c_cur_on, c_busy, c_done;
  logic [1:0] c_req_sel, c_cur_sel;
  logic [3:0] c_sel;

  la_clkmux4_ctrl u_dut_a (
    .clk(clk), .nreset(a_nreset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_sel(a_req_sel), .req_off(a_req_off), .sel(a_sel), .cur_sel(a_cur_sel),
    .cur_on(a_cur_on), .busy(a_busy), .done(a_done)
  );

  la_clkmux4_ctrl #(.RESET_SEL(2)) u_dut_b (
    .clk(clk), .nreset(b_nreset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_sel(b_req_sel), .req_off(b_req_off), .sel(b_sel), .cur_sel(b_cur_sel),
    .cur_on(b_cur_on), .busy(b_busy), .done(b_done)
  );

  la_clkmux4_ctrl #(.DRAIN_CYCLES(3), .SETTLE_CYCLES(5), .RESET_SEL(0)) u_dut_c (
    .clk(clk), .nreset(c_nreset), .req_valid(c_req_valid), .req_ready(c_req_ready),
    .req_sel(c_req_sel), .req_off(c_req_off), .sel(c_sel), .cur_sel(c_cur_sel),
    .cur_on(c_cur_on), .busy(c_busy), .done(c_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariant watch on instance A: no multi-hot, no direct hop, drain honoured.
  int         a_viol = 0;
  int         a_zrun = 100;
  logic [3:0] a_prev = 4'b0001;
  always @(negedge clk) begin
    if ($countones(a_sel) > 1) a_viol++;
    if (a_prev != 4'b0000 && a_sel != 4'b0000 && a_sel != a_prev) a_viol++;
    if (a_prev == 4'b0000 && a_sel != 4'b0000 && a_zrun < 8) a_viol++;
    a_zrun = (a_sel == 4'b0000) ? a_zrun + 1 : 0;
    a_prev = a_sel;
  end

  // Issue one request on A and measure accept-to-done latency; -1 on timeout.
  task automatic a_issue(input logic off, input logic [1:0] s, output int lat,
                         output int zeros, output int busy_n, output bit changed);
    logic [3:0] sel0;
    int w;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_sel = s; a_req_off = off;
    w = 0;
    while (!a_req_ready && w < 50) begin @(negedge clk); w++; end
    sel0 = a_sel;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = -1; zeros = 0; busy_n = 0; changed = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (a_sel == 4'b0000) zeros++;
      if (a_busy) busy_n++;
      if (a_sel != sel0) changed = 1'b1;
      if (a_done) begin lat = k; break; end
    end
  endtask

  task automatic c_issue(input logic [1:0] s, output int lat);
    int w;
    @(negedge clk);
    c_req_valid = 1'b1; c_req_sel = s; c_req_off = 1'b0;
    w = 0;
    while (!c_req_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (c_done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (b_sel !== 4'b0100) begin n_err++; $display("FAIL rst_sel got %b want 0100", b_sel); end
    n_cmp++; if (b_cur_sel !== 2'd2) begin n_err++; $display("FAIL rst_cur_sel got %0d want 2", b_cur_sel); end
    n_cmp++; if (b_cur_on !== 1'b1) begin n_err++; $display("FAIL rst_cur_on got %b want 1", b_cur_on); end
    n_cmp++; if ({b_req_ready, b_busy, b_done} !== 3'b100) begin
      n_err++; $display("FAIL rst_ready_busy_done got %b want 100", {b_req_ready, b_busy, b_done});
    end
    // Start a switch to 0, then reset asynchronously while draining.
    b_req_valid = 1'b1; b_req_sel = 2'd0; b_req_off = 1'b0;
    @(posedge clk); #1; b_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (b_sel !== 4'b0000 || b_busy !== 1'b1) begin
      n_err++; $display("FAIL drain_entry got sel=%b busy=%b want 0000 1", b_sel, b_busy);
    end
    #1 b_nreset = 1'b0;
    #1;
    n_cmp++; if (b_sel !== 4'b0100 || b_cur_sel !== 2'd2 || b_cur_on !== 1'b1) begin
      n_err++; $display("FAIL async_rst got sel=%b cur=%0d on=%b want 0100 2 1", b_sel, b_cur_sel, b_cur_on);
    end
    n_cmp++; if ({b_req_ready, b_busy, b_done} !== 3'b100) begin
      n_err++; $display("FAIL async_rst_state got %b want 100", {b_req_ready, b_busy, b_done});
    end
    @(negedge clk); b_nreset = 1'b1;
  endtask

  task automatic test_full_switch();
    int lat, zeros, busy_n; bit ch;
    a_issue(1'b0, 2'd1, lat, zeros, busy_n, ch);
    n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL full_lat got %0d want 17", lat); end
    n_cmp++; if (zeros !== 8) begin n_err++; $display("FAIL full_drain got %0d want 8", zeros); end
    n_cmp++; if (busy_n !== 17) begin n_err++; $display("FAIL full_busy got %0d want 17", busy_n); end
    n_cmp++; if (a_sel !== 4'b0010 || a_cur_sel !== 2'd1 || a_cur_on !== 1'b1) begin
      n_err++; $display("FAIL full_end got sel=%b cur=%0d on=%b want 0010 1 1", a_sel, a_cur_sel, a_cur_on);
    end
    n_cmp++; if (a_req_ready !== 1'b0) begin n_err++; $display("FAIL fin_ready got %b want 0", a_req_ready); end
    @(negedge clk);
    n_cmp++; if (a_req_ready !== 1'b1 || a_done !== 1'b0) begin
      n_err++; $display("FAIL post_fin got ready=%b done=%b want 1 0", a_req_ready, a_done);
    end
  endtask

  task automatic test_noop();
    int lat, zeros, busy_n; bit ch;
    a_issue(1'b0, 2'd1, lat, zeros, busy_n, ch);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL noop_lat got %0d want 1", lat); end
    n_cmp++; if (busy_n !== 1) begin n_err++; $display("FAIL noop_busy got %0d want 1", busy_n); end
    n_cmp++; if (ch !== 1'b0 || a_sel !== 4'b0010) begin
      n_err++; $display("FAIL noop_sel got changed=%b sel=%b want 0 0010", ch, a_sel);
    end
  endtask

  task automatic test_off();
    int lat, zeros, busy_n; bit ch;
    a_issue(1'b0, 2'd3, lat, zeros, busy_n, ch);
    n_cmp++; if (lat !== 17 || a_sel !== 4'b1000) begin
      n_err++; $display("FAIL to3 got lat=%0d sel=%b want 17 1000", lat, a_sel);
    end
    a_issue(1'b1, 2'd2, lat, zeros, busy_n, ch);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL off_lat got %0d want 9", lat); end
    n_cmp++; if (zeros !== 9) begin n_err++; $display("FAIL off_zero got %0d want 9", zeros); end
    n_cmp++; if (a_cur_on !== 1'b0 || a_sel !== 4'b0000) begin
      n_err++; $display("FAIL off_end got on=%b sel=%b want 0 0000", a_cur_on, a_sel);
    end
    a_issue(1'b1, 2'd0, lat, zeros, busy_n, ch);
    n_cmp++; if (lat !== 1 || a_cur_on !== 1'b0) begin
      n_err++; $display("FAIL off_noop got lat=%0d on=%b want 1 0", lat, a_cur_on);
    end
  endtask

  task automatic test_back_to_back();
    int lat, zeros, busy_n; bit ch;
    int first_done, second_done, early_ready;
    a_issue(1'b0, 2'd0, lat, zeros, busy_n, ch);
    n_cmp++; if (lat !== 17 || a_sel !== 4'b0001) begin
      n_err++; $display("FAIL from_off got lat=%0d sel=%b want 17 0001", lat, a_sel);
    end
    @(negedge clk);
    a_req_valid = 1'b1; a_req_sel = 2'd1; a_req_off = 1'b0;
    @(posedge clk); #1;
    a_req_sel = 2'd2;
    first_done = -1; second_done = -1; early_ready = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 19) a_req_valid = 1'b0;
      if (k < 17 && a_req_ready) early_ready++;
      if (a_done && first_done < 0) first_done = k;
      else if (a_done) begin second_done = k; break; end
    end
    a_req_valid = 1'b0;
    n_cmp++; if (early_ready !== 0) begin n_err++; $display("FAIL busy_ready got %0d want 0", early_ready); end
    n_cmp++; if (first_done !== 17) begin n_err++; $display("FAIL b2b_first got %0d want 17", first_done); end
    n_cmp++; if (second_done !== 35) begin n_err++; $display("FAIL b2b_second got %0d want 35", second_done); end
    n_cmp++; if (a_cur_sel !== 2'd2 || a_sel !== 4'b0100) begin
      n_err++; $display("FAIL b2b_end got cur=%0d sel=%b want 2 0100", a_cur_sel, a_sel);
    end
    n_cmp++; if (a_viol !== 0) begin n_err++; $display("FAIL sel_invariant got %0d want 0", a_viol); end
  endtask

  task automatic test_reset_mid_settle();
    int lat, dones;
    @(negedge clk);
    c_req_valid = 1'b1; c_req_sel = 2'd2; c_req_off = 1'b0;
    @(posedge clk); #1; c_req_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (c_sel !== 4'b0100 || c_busy !== 1'b1) begin
      n_err++; $display("FAIL settle_entry got sel=%b busy=%b want 0100 1", c_sel, c_busy);
    end
    #1 c_nreset = 1'b0;
    #1;
    n_cmp++; if (c_sel !== 4'b0001 || c_busy !== 1'b0 || c_cur_sel !== 2'd0 || c_cur_on !== 1'b1) begin
      n_err++; $display("FAIL settle_rst got sel=%b busy=%b cur=%0d on=%b want 0001 0 0 1",
                        c_sel, c_busy, c_cur_sel, c_cur_on);
    end
    @(negedge clk); c_nreset = 1'b1;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (c_done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL dropped_done got %0d want 0", dones); end
    c_issue(2'd3, lat);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL c_lat got %0d want 9", lat); end
    n_cmp++; if (c_sel !== 4'b1000 || c_cur_sel !== 2'd3 || c_cur_on !== 1'b1) begin
      n_err++; $display("FAIL c_end got sel=%b cur=%0d on=%b want 1000 3 1", c_sel, c_cur_sel, c_cur_on);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    a_nreset = 1'b0; b_nreset = 1'b0; c_nreset = 1'b0;
    a_req_valid = 1'b0; a_req_sel = 2'd0; a_req_off = 1'b0;
    b_req_valid = 1'b0; b_req_sel = 2'd0; b_req_off = 1'b0;
    c_req_valid = 1'b0; c_req_sel = 2'd0; c_req_off = 1'b0;
    repeat (2) @(negedge clk);
    a_nreset = 1'b1; b_nreset = 1'b1; c_nreset = 1'b1;
    test_reset();
    test_full_switch();
    test_noop();
    test_off();
    test_back_to_back();
    test_reset_mid_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
